// File: rtl/riscv_stream_arbiter.sv
// riscv_stream_arbiter: round-robin valid/ready arbiter with bursty grants and a registered, source-tagged output stage
module riscv_stream_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN*DATA_WIDTH-1:0] din,
  input  logic [NUM_IN-1:0]            val_in,
  output logic [NUM_IN-1:0]            ready_upward,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         val_out,
  output logic [IDX_WIDTH-1:0]         src_id,
  input  logic                         ready_downward,
  output logic [NUM_IN-1:0]            grant
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] g_idx, last, pick, cand;
  logic [CW-1:0]        beat_cnt;
  logic                 found, out_free, up_xfer;
  int                   c;

  assign out_free     = !val_out || ready_downward;
  assign ready_upward = (state == GRANT && out_free) ? grant : '0;
  assign up_xfer      = |(val_in & ready_upward);

  // first requester after the last one served, wrapping around
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      c    = (int'(last) + k) % NUM_IN;
      cand = IDX_WIDTH'(c);
      if (!found && val_in[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // grant FSM: hold a grant until the burst limit or the requester drops valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      g_idx    <= '0;
      beat_cnt <= '0;
      last     <= IDX_WIDTH'(NUM_IN - 1);
    end else if (state == IDLE) begin
      if (found) begin
        state    <= GRANT;
        grant    <= NUM_IN'(1) << pick;
        g_idx    <= pick;
        beat_cnt <= '0;
      end
    end else if (!val_in[g_idx] || (up_xfer && beat_cnt == CW'(MAX_BURST - 1))) begin
      state <= IDLE;
      grant <= '0;
      last  <= g_idx;
    end else if (up_xfer) begin
      beat_cnt <= beat_cnt + 1'b1;
    end

  // single output register: load on accept, empty on downstream take
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      val_out <= 1'b0;
      dout    <= '0;
      src_id  <= '0;
    end else if (up_xfer) begin
      dout    <= din[g_idx*DATA_WIDTH +: DATA_WIDTH];
      src_id  <= g_idx;
      val_out <= 1'b1;
    end else if (ready_downward) begin
      val_out <= 1'b0;
    end
endmodule
